// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack memory handshake, valid/stall output slot
// backed by a one-entry skid buffer, and redirect with flush of unconsumed work.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  localparam logic [31:0] PC_RST = RESET_PC & ~32'h3;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      r_state,     w_state_next;
  logic [31:0] r_pc,        w_pc_next;
  logic [31:0] r_req_addr,  w_req_addr_next;
  logic [31:0] r_instr,     w_instr_next;
  logic [31:0] r_instr_pc,  w_instr_pc_next;
  logic        r_instr_vld, w_instr_vld_next;
  logic [31:0] r_buf,       w_buf_next;
  logic [31:0] r_buf_pc,    w_buf_pc_next;
  logic        r_buf_vld,   w_buf_vld_next;
  logic        w_slot_free;
  logic        w_consumed;
  logic [31:0] w_target;

  assign w_slot_free = !r_instr_vld || !stall;
  assign w_consumed  = r_instr_vld && !stall;
  assign w_target    = redirect_pc & ~32'h3;

  // NOTE: every signal gets its hold value first so no path through the case
  // below leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_instr_next     = r_instr;
    w_instr_pc_next  = r_instr_pc;
    w_instr_vld_next = r_instr_vld;
    w_buf_next       = r_buf;
    w_buf_pc_next    = r_buf_pc;
    w_buf_vld_next   = r_buf_vld;
    imem_req         = 1'b0;

    case (r_state)
      IDLE: w_state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_pc_next = r_pc + 32'd4;
          if (w_slot_free) begin
            w_instr_next     = imem_rdata;
            w_instr_pc_next  = r_pc;
            w_instr_vld_next = 1'b1;
          end else begin
            w_buf_next     = imem_rdata;
            w_buf_pc_next  = r_pc;
            w_buf_vld_next = 1'b1;
            w_state_next   = HOLD;
          end
        end else if (w_consumed) begin
          w_instr_vld_next = 1'b0;
        end
      end
      HOLD: begin
        if (!stall) begin
          w_instr_next     = r_buf;
          w_instr_pc_next  = r_buf_pc;
          w_instr_vld_next = 1'b1;
          w_buf_vld_next   = 1'b0;
          w_state_next     = FETCH;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (w_consumed) w_instr_vld_next = 1'b0;
        if (imem_ack)   w_state_next     = FETCH;
      end
      default: w_state_next = IDLE;
    endcase

    // Redirect overrides everything above; any data accepted this cycle is dropped.
    if (redirect && r_state != IDLE) begin
      w_instr_vld_next = 1'b0;
      w_buf_vld_next   = 1'b0;
      w_pc_next        = w_target;
      case (r_state)
        FETCH:   w_state_next = imem_ack ? FETCH : DRAIN;
        HOLD:    w_state_next = FETCH;
        default: w_state_next = DRAIN;
      endcase
    end

    // The outstanding request address must stay put until the drained ack.
    w_req_addr_next = (w_state_next == DRAIN) ? r_req_addr : w_pc_next;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= PC_RST;
      r_req_addr  <= PC_RST;
      r_instr     <= NOP;
      r_instr_pc  <= 32'h0;
      r_instr_vld <= 1'b0;
      r_buf       <= NOP;
      r_buf_pc    <= 32'h0;
      r_buf_vld   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_req_addr  <= w_req_addr_next;
      r_instr     <= w_instr_next;
      r_instr_pc  <= w_instr_pc_next;
      r_instr_vld <= w_instr_vld_next;
      r_buf       <= w_buf_next;
      r_buf_pc    <= w_buf_pc_next;
      r_buf_vld   <= w_buf_vld_next;
    end
  end

  assign imem_addr   = r_req_addr;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_vld;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, skid stall, drained redirect,
// redirect over a full skid slot, PC wrap, and reset while draining.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory word is address-derived so every returned beat is distinguishable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Zero-latency memory: acknowledge whatever is requested in the same cycle.
  task automatic mem0();
    imem_ack   = imem_req;
    imem_rdata = imem_req ? mem_word(imem_addr) : 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_req",   {31'b0, imem_req},    32'h0);
    check("rst_addr",  imem_addr,            32'h0000_0100);
    check("rst_instr", instr,                32'h0000_0013);
    check("rst_ipc",   instr_pc,             32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    rst = 1'b0;

    // Streaming with zero-latency memory
    tick();
    check("start_req",   {31'b0, imem_req},    32'h1);
    check("start_addr",  imem_addr,            32'h0000_0100);
    check("start_valid", {31'b0, instr_valid}, 32'h0);
    mem0(); tick();
    check("s0_pc",    instr_pc,             32'h0000_0100);
    check("s0_instr", instr,                32'hA5A5_0100);
    check("s0_valid", {31'b0, instr_valid}, 32'h1);
    mem0(); tick();
    check("s1_pc",    instr_pc,             32'h0000_0104);
    check("s1_instr", instr,                32'hA5A5_0104);

    // Three stall cycles: 0x108 goes to the skid slot, requests stop
    stall = 1'b1;
    mem0(); tick();
    check("st0_pc",  instr_pc,          32'h0000_0104);
    check("st0_req", {31'b0, imem_req}, 32'h0);
    mem0(); tick();
    check("st1_pc",  instr_pc,          32'h0000_0104);
    check("st1_req", {31'b0, imem_req}, 32'h0);
    mem0(); tick();
    check("st2_pc",    instr_pc,             32'h0000_0104);
    check("st2_valid", {31'b0, instr_valid}, 32'h1);
    stall = 1'b0;
    mem0(); tick();
    check("rel_pc",    instr_pc,          32'h0000_0108);
    check("rel_instr", instr,             32'hA5A5_0108);
    check("rel_req",   {31'b0, imem_req}, 32'h1);
    check("rel_addr",  imem_addr,         32'h0000_010C);

    // Slow memory, redirect one cycle after the 0x10C request
    imem_ack = 1'b0; tick();
    check("slow_valid", {31'b0, instr_valid}, 32'h0);
    check("slow_addr",  imem_addr,            32'h0000_010C);
    redirect = 1'b1; redirect_pc = 32'h0000_2002;
    tick();
    redirect = 1'b0;
    check("drn0_req",   {31'b0, imem_req},    32'h1);
    check("drn0_addr",  imem_addr,            32'h0000_010C);
    check("drn0_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    check("drn1_addr", imem_addr, 32'h0000_010C);
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0000_010C);
    tick();
    check("drn_done_valid", {31'b0, instr_valid}, 32'h0);
    check("drn_done_addr",  imem_addr,            32'h0000_2000);
    mem0(); tick();
    check("tgt_pc",    instr_pc,             32'h0000_2000);
    check("tgt_instr", instr,                32'hA5A5_2000);
    check("tgt_valid", {31'b0, instr_valid}, 32'h1);

    // Redirect while stalled with the skid slot full
    stall = 1'b1;
    mem0(); tick();
    check("hold_req", {31'b0, imem_req}, 32'h0);
    check("hold_pc",  instr_pc,          32'h0000_2000);
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    check("rdh_valid", {31'b0, instr_valid}, 32'h0);
    check("rdh_req",   {31'b0, imem_req},    32'h1);
    check("rdh_addr",  imem_addr,            32'h0000_0300);
    mem0(); tick();
    check("rdh_first_pc",    instr_pc,             32'h0000_0300);
    check("rdh_first_instr", instr,                32'hA5A5_0300);
    check("rdh_first_valid", {31'b0, instr_valid}, 32'h1);
    stall = 1'b0;

    // Redirect together with an ack (data dropped), then PC wrap
    mem0(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    check("wrap_drop_valid", {31'b0, instr_valid}, 32'h0);
    check("wrap_addr",       imem_addr,            32'hFFFF_FFFC);
    mem0(); tick();
    check("wrap_pc",    instr_pc,  32'hFFFF_FFFC);
    check("wrap_instr", instr,     32'h5A5A_FFFC);
    check("wrap_next",  imem_addr, 32'h0000_0000);

    // Enter DRAIN, then reset mid-operation
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0400;
    tick();
    redirect = 1'b0;
    check("pre_rst_req",  {31'b0, imem_req}, 32'h1);
    check("pre_rst_addr", imem_addr,         32'h0000_0000);
    rst = 1'b1;
    #1;
    check("mid_rst_req",   {31'b0, imem_req},    32'h0);
    check("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
    check("mid_rst_addr",  imem_addr,            32'h0000_0100);
    tick();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("late_ack_valid", {31'b0, instr_valid}, 32'h0);
    check("late_ack_instr", instr,                32'h0000_0013);
    check("restart_req",    {31'b0, imem_req},    32'h1);
    check("restart_addr",   imem_addr,            32'h0000_0100);
    mem0(); tick();
    check("restart_pc",    instr_pc,             32'h0000_0100);
    check("restart_instr", instr,                32'hA5A5_0100);
    check("restart_valid", {31'b0, instr_valid}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
